// File: rtl/mux_stream_rr.sv
// mux_stream_rr: N-input registered stream mux that locks onto one channel per packet.
// Define MUX_STREAM_RR_PKT_CNT_EN to add the 16-bit completed-packet counter output pkt_count.
module mux_stream_rr #(
  parameter int WIDTH = 8,
  parameter int N_IN  = 4,
  parameter int MODE  = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_IN*WIDTH-1:0]   in_data,
  input  logic [N_IN-1:0]         in_valid,
  input  logic [N_IN-1:0]         in_last,
  output logic [N_IN-1:0]         in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  output logic                    out_last,
  output logic [$clog2(N_IN)-1:0] out_sel,
  input  logic                    out_ready
`ifdef MUX_STREAM_RR_PKT_CNT_EN
  ,
  output logic [15:0]             pkt_count
`endif
);

  localparam int SEL_W = $clog2(N_IN);
  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(N_IN - 1);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic [SEL_W-1:0] grant_r;
  logic [SEL_W-1:0] grant_s;
  logic [SEL_W-1:0] rr_ptr_r;
  logic [SEL_W-1:0] rr_ptr_s;
  logic [SEL_W-1:0] winner_s;
  logic [WIDTH-1:0] grant_data_s;
  logic             space_s;
  logic             accept_s;

  // Arbitration: first valid channel scanning upward from the start index, wrapping at N_IN.
  always_comb begin
    logic [SEL_W-1:0] start_v;
    logic             found_v;
    int               idx_v;
    winner_s = '0;
    found_v  = 1'b0;
    idx_v    = 0;
    start_v  = (MODE == 0) ? rr_ptr_r : '0;
    for (int k = 0; k < N_IN; k++) begin
      idx_v = (int'(start_v) + k) % N_IN;
      if (!found_v && in_valid[SEL_W'(idx_v)]) begin
        winner_s = SEL_W'(idx_v);
        found_v  = 1'b1;
      end else begin
        found_v  = found_v;
      end
    end
  end

  // Data mux for the granted channel.
  always_comb begin
    grant_data_s = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (grant_r == SEL_W'(i)) begin
        grant_data_s = in_data[i*WIDTH +: WIDTH];
      end else begin
        grant_data_s = grant_data_s;
      end
    end
  end

  // Next-state, grant and handshake logic.
  always_comb begin
    state_s  = state_r;
    grant_s  = grant_r;
    rr_ptr_s = rr_ptr_r;
    in_ready = '0;
    accept_s = 1'b0;
    space_s  = !out_valid || out_ready;
    case (state_r)
      IDLE: begin
        if (|in_valid) begin
          state_s = LOCKED;
          grant_s = winner_s;
        end else begin
          state_s = IDLE;
        end
      end
      LOCKED: begin
        in_ready[grant_r] = space_s;
        accept_s          = space_s && in_valid[grant_r];
        // Leaving on the last beat; the next arbitration happens one cycle later from IDLE.
        if (accept_s && in_last[grant_r]) begin
          state_s  = IDLE;
          rr_ptr_s = (grant_r == LAST_IDX) ? '0 : grant_r + SEL_W'(1);
        end else begin
          state_s  = LOCKED;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and output register; holds the beat while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      grant_r   <= '0;
      rr_ptr_r  <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_sel   <= '0;
    end else begin
      state_r  <= state_s;
      grant_r  <= grant_s;
      rr_ptr_r <= rr_ptr_s;
      if (accept_s) begin
        out_valid <= 1'b1;
        out_data  <= grant_data_s;
        out_last  <= in_last[grant_r];
        out_sel   <= grant_r;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef MUX_STREAM_RR_PKT_CNT_EN
  // Counts packets completed on the output side; wraps naturally at 16 bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkt_count <= 16'h0000;
    end else if (out_valid && out_ready && out_last) begin
      pkt_count <= pkt_count + 16'h0001;
    end
  end
`endif

endmodule

// File: tb/tb_mux_stream_rr.sv
// Randomized bench for mux_stream_rr: a round-robin and a fixed-priority instance, each
// checked against a transaction-level reference model (packet sources plus expected beat queue).
module tb_mux_stream_rr;
  localparam int WIDTH = 8;
  localparam int N     = 4;
  localparam int SW    = $clog2(N);

  typedef struct packed {
    logic [SW-1:0]    sel;
    logic [WIDTH-1:0] data;
    logic             last;
  } beat_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [N*WIDTH-1:0] in_data   [2];
  logic [N-1:0]       in_valid  [2];
  logic [N-1:0]       in_last   [2];
  logic [N-1:0]       in_ready  [2];
  logic [WIDTH-1:0]   out_data  [2];
  logic               out_valid [2];
  logic               out_last  [2];
  logic [SW-1:0]      out_sel   [2];
  logic               out_ready [2];
`ifdef MUX_STREAM_RR_PKT_CNT_EN
  logic [15:0]        pkt_count [2];
`endif

  mux_stream_rr #(.WIDTH(WIDTH), .N_IN(N), .MODE(0)) dut0 (
    .clk(clk), .rst(rst), .in_data(in_data[0]), .in_valid(in_valid[0]), .in_last(in_last[0]),
    .in_ready(in_ready[0]), .out_data(out_data[0]), .out_valid(out_valid[0]),
    .out_last(out_last[0]), .out_sel(out_sel[0]), .out_ready(out_ready[0])
`ifdef MUX_STREAM_RR_PKT_CNT_EN
    , .pkt_count(pkt_count[0])
`endif
  );

  mux_stream_rr #(.WIDTH(WIDTH), .N_IN(N), .MODE(1)) dut1 (
    .clk(clk), .rst(rst), .in_data(in_data[1]), .in_valid(in_valid[1]), .in_last(in_last[1]),
    .in_ready(in_ready[1]), .out_data(out_data[1]), .out_valid(out_valid[1]),
    .out_last(out_last[1]), .out_sel(out_sel[1]), .out_ready(out_ready[1])
`ifdef MUX_STREAM_RR_PKT_CNT_EN
    , .pkt_count(pkt_count[1])
`endif
  );

  int n_cmp;
  int n_bad;

  // Source state per instance and channel
  logic             pres  [2][N];
  int               rem   [2][N];
  int               bidx  [2][N];
  logic [WIDTH-1:0] sdata [2][N];
  logic             slast [2][N];
  logic [N-1:0]     en    [2];

  // Stimulus knobs
  int p_valid, p_ready, min_len, max_len, dmode;
  bit rdy_tog;

  // Reference model state
  beat_t oq   [2][$];
  bit    busy [2];
  int    grant[2];
  int    ptr  [2];
  int    pkts [2];
  int    selhist[5];
  int    nsel;
  int    ch3_seen;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pick(input int d);
    int c;
    for (int k = 0; k < N; k++) begin
      c = (d == 0) ? (ptr[d] + k) % N : k;
      if (in_valid[d][c]) return c;
    end
    return -1;
  endfunction

  task automatic drive();
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < N; c++) begin
        if (!pres[d][c] && en[d][c] && ($urandom_range(99) < p_valid)) begin
          if (rem[d][c] == 0) begin
            rem[d][c]  = int'($urandom_range(max_len, min_len));
            bidx[d][c] = 0;
          end
          pres[d][c] = 1'b1;
          case (dmode)
            1:       sdata[d][c] = 8'(32'h10 + c);
            2:       sdata[d][c] = 8'(32'hA0 + bidx[d][c]);
            default: sdata[d][c] = 8'($urandom);
          endcase
          slast[d][c] = (rem[d][c] == 1);
        end
        in_valid[d][c]              = pres[d][c];
        in_data[d][c*WIDTH +: WIDTH] = sdata[d][c];
        in_last[d][c]               = slast[d][c];
      end
      out_ready[d] = rdy_tog ? ~out_ready[d] : ($urandom_range(99) < p_ready);
    end
  endtask

  // Called between edges: checks outputs, then applies what the next rising edge will do.
  task automatic step(input int d);
    bit           ev;
    bit           space;
    logic [N-1:0] exp_rdy;
    beat_t        b;
    int           g;
    ev = (oq[d].size() != 0);
    chk($sformatf("d%0d_out_valid", d), 32'(out_valid[d]), 32'(ev));
    if (ev) begin
      chk($sformatf("d%0d_out_data", d), 32'(out_data[d]), 32'(oq[d][0].data));
      chk($sformatf("d%0d_out_last", d), 32'(out_last[d]), 32'(oq[d][0].last));
      chk($sformatf("d%0d_out_sel", d), 32'(out_sel[d]), 32'(oq[d][0].sel));
    end
`ifdef MUX_STREAM_RR_PKT_CNT_EN
    chk($sformatf("d%0d_pkt_count", d), 32'(pkt_count[d]), 32'(pkts[d] % 65536));
`endif
    space   = !ev || out_ready[d];
    exp_rdy = '0;
    if (busy[d] && space) exp_rdy[grant[d]] = 1'b1;
    chk($sformatf("d%0d_in_ready", d), 32'(in_ready[d]), 32'(exp_rdy));

    if (ev && out_ready[d]) begin
      if (oq[d][0].last) pkts[d]++;
      if (d == 0 && nsel < 5) begin
        selhist[nsel] = int'(oq[d][0].sel);
        nsel++;
      end
      if (d == 1 && oq[d][0].sel == SW'(3)) ch3_seen++;
      void'(oq[d].pop_front());
    end
    if (busy[d]) begin
      g = grant[d];
      if (in_valid[d][g] && space) begin
        b.sel  = SW'(g);
        b.data = in_data[d][g*WIDTH +: WIDTH];
        b.last = in_last[d][g];
        oq[d].push_back(b);
        pres[d][g] = 1'b0;
        rem[d][g]--;
        bidx[d][g]++;
        if (b.last) begin
          busy[d] = 1'b0;
          ptr[d]  = (g + 1) % N;
        end
      end
    end else if (in_valid[d] != '0) begin
      busy[d]  = 1'b1;
      grant[d] = pick(d);
    end
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      drive();
      @(negedge clk);
      step(0);
      step(1);
    end
  endtask

  // Asserts reset mid-cycle, checks the reset state with sources valid, releases on a falling edge.
  task automatic do_reset();
    #2;
    rst = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("d%0d_rst_out_valid", d), 32'(out_valid[d]), 32'd0);
      oq[d].delete();
      busy[d] = 1'b0;
      ptr[d]  = 0;
      pkts[d] = 0;
      for (int c = 0; c < N; c++) begin
        pres[d][c] = 1'b0;
        rem[d][c]  = 0;
      end
    end
    drive();
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("d%0d_rst_in_ready", d), 32'(in_ready[d]), 32'd0);
      chk($sformatf("d%0d_rst_out_sel", d), 32'(out_sel[d]), 32'd0);
      chk($sformatf("d%0d_rst_out_valid_hold", d), 32'(out_valid[d]), 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    step(0);
    step(1);
  endtask

  initial begin
    n_cmp    = 0;
    n_bad    = 0;
    nsel     = 0;
    ch3_seen = 0;
    rst      = 1'b1;
    for (int d = 0; d < 2; d++) begin
      out_ready[d] = 1'b1;
      for (int c = 0; c < N; c++) begin
        sdata[d][c] = '0;
        slast[d][c] = 1'b0;
        bidx[d][c]  = 0;
      end
    end

    // Single-beat packets on every channel: rotation (MODE 0) and starvation (MODE 1)
    en[0] = 4'b1111;  en[1] = 4'b1010;
    p_valid = 100;  p_ready = 100;  min_len = 1;  max_len = 1;  dmode = 1;  rdy_tog = 1'b0;
    do_reset();
    run(40);
    for (int i = 0; i < 5; i++) chk("rr_sel_order", 32'(selhist[i]), 32'(i % 4));
    chk("prio_ch3_starved", 32'(ch3_seen), 32'd0);
    chk("prio_ch1_served", 32'(pkts[1] > 5), 32'd1);

    // Three-beat packets under a toggling consumer
    en[0] = 4'b0101;
    min_len = 3;  max_len = 3;  dmode = 2;  rdy_tog = 1'b1;
    run(80);

    // Random traffic: gaps, random lengths, random back-pressure
    en[0] = 4'b1111;  en[1] = 4'b1111;
    p_valid = 50;  p_ready = 60;  min_len = 1;  max_len = 4;  dmode = 0;  rdy_tog = 1'b0;
    run(1500);

    // Reset during traffic, then a lone channel 1 sending 4-beat packets
    en[0] = 4'b0010;  en[1] = 4'b0010;
    p_valid = 100;  p_ready = 100;  min_len = 4;  max_len = 4;
    do_reset();
    run(40);
    chk("ch1_pkts_after_rst", 32'(pkts[0] >= 5), 32'd1);

    // Stop starting beats and let the output drain
    p_valid = 0;
    run(40);
    chk("d0_drained", 32'(out_valid[0]), 32'd0);
    chk("d1_drained", 32'(out_valid[1]), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
